// File: rtl/hopfield_sequencer.sv
// Hopfield network train/recall sequencer with pattern buffer.
// Define HOPFIELD_SEQ_TIMEOUT_EN to bound RECALL by TIMEOUT cycles.
module hopfield_sequencer #(
  parameter int NUM_PAT       = 4,
  parameter int HOLD_CYCLES   = 8,
  parameter int EPOCHS        = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int TIMEOUT       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  input  logic [3:0] load_data,
  output logic       load_ready,
  input  logic       clear_patterns,
  input  logic       train_start,
  input  logic       recall_start,
  input  logic [3:0] probe,
  input  logic [6:0] net_spikes,
  output logic       net_learning_enable,
  output logic [3:0] net_pattern,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [6:0] result,
  output logic [2:0] pat_count
);

  localparam int IW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int EW = (EPOCHS > 1) ? $clog2(EPOCHS) : 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    TRAIN,
    RECALL,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    pat_mem [NUM_PAT];
  logic [IW-1:0] idx;
  logic [HW-1:0] hold;
  logic [EW-1:0] epoch;
  logic [3:0]    pat_q;
  logic [6:0]    prev;
  logic [SW-1:0] stable;
  logic [SW-1:0] stable_nx;

  logic idle;
  logic clr_go;
  logic train_go;
  logic recall_go;
  logic load_go;
  logic hold_end;
  logic idx_end;
  logic ep_end;
  logic train_last;
  logic converged;
  logic expired;

  assign idle = (state == IDLE);
  assign clr_go = idle && clear_patterns;
  assign train_go = idle && !clear_patterns && train_start
                    && (pat_count != 3'd0);
  assign recall_go = idle && !clear_patterns && !train_start
                     && recall_start;
  assign load_ready = idle && (pat_count < 3'(NUM_PAT))
                      && !train_start && !recall_start
                      && !clear_patterns;
  assign load_go = load_valid && load_ready;

  assign hold_end = (hold == HW'(HOLD_CYCLES - 1));
  assign idx_end = (idx == IW'(pat_count - 3'd1));
  assign ep_end = (epoch == EW'(EPOCHS - 1));
  assign train_last = hold_end && idx_end && ep_end;

  assign stable_nx = (net_spikes == prev) ? stable + SW'(1) : '0;
  assign converged = (stable_nx == SW'(STABLE_CYCLES));

`ifdef HOPFIELD_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] cyc;

  assign expired = (cyc == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc <= '0;
    end else if (recall_go) begin
      cyc <= '0;
    end else if (state == RECALL) begin
      cyc <= cyc + TW'(1);
    end
  end
`else
  // Feature off: recall never expires.
  assign expired = (TIMEOUT < 0);
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (train_go) state_nx = TRAIN;
        else if (recall_go) state_nx = RECALL;
      end
      TRAIN:  if (train_last) state_nx = DONE;
      RECALL: if (converged || expired) state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_go) pat_mem[pat_count[IW-1:0]] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pat_count <= '0;
      idx       <= '0;
      hold      <= '0;
      epoch     <= '0;
      pat_q     <= '0;
      prev      <= '0;
      stable    <= '0;
      timeout   <= 1'b0;
      result    <= '0;
    end else begin
      state <= state_nx;
      if (clr_go) pat_count <= '0;
      else if (load_go) pat_count <= pat_count + 3'd1;
      if (train_go) begin
        idx   <= '0;
        hold  <= '0;
        epoch <= '0;
      end
      if (state == TRAIN) begin
        pat_q <= pat_mem[idx];
        if (hold_end) begin
          hold <= '0;
          if (idx_end) begin
            idx   <= '0;
            epoch <= epoch + EW'(1);
          end else begin
            idx <= idx + IW'(1);
          end
        end else begin
          hold <= hold + HW'(1);
        end
      end
      if (recall_go) begin
        pat_q   <= probe;
        prev    <= net_spikes;
        stable  <= '0;
        timeout <= 1'b0;
      end
      if (state == RECALL) begin
        prev   <= net_spikes;
        stable <= stable_nx;
        if (converged) begin
          result <= net_spikes;
        end else if (expired) begin
          result  <= net_spikes;
          timeout <= 1'b1;
        end
      end
    end
  end

  // TRAIN drives the buffer directly; elsewhere the last value holds.
  assign net_pattern = (state == TRAIN) ? pat_mem[idx] : pat_q;
  assign net_learning_enable = (state == TRAIN);
  assign busy = (state == TRAIN) || (state == RECALL);
  assign done = (state == DONE);

endmodule

// File: tb/tb_hopfield_sequencer.sv
// Scoreboard bench for hopfield_sequencer: random loads, training
// runs and recall spike sequences against a pattern-level model.
module tb_hopfield_sequencer;

  localparam int NUM_PAT = 4;
  localparam int HOLD    = 8;
  localparam int EPOCHS  = 4;
  localparam int STABLE  = 3;
  localparam int TMO     = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [3:0] load_data;
  logic       load_ready;
  logic       clear_patterns;
  logic       train_start;
  logic       recall_start;
  logic [3:0] probe;
  logic [6:0] net_spikes;
  logic       net_learning_enable;
  logic [3:0] net_pattern;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [6:0] result;
  logic [2:0] pat_count;

  hopfield_sequencer #(
    .NUM_PAT(NUM_PAT),
    .HOLD_CYCLES(HOLD),
    .EPOCHS(EPOCHS),
    .STABLE_CYCLES(STABLE),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .clear_patterns(clear_patterns),
    .train_start(train_start),
    .recall_start(recall_start),
    .probe(probe),
    .net_spikes(net_spikes),
    .net_learning_enable(net_learning_enable),
    .net_pattern(net_pattern),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .result(result),
    .pat_count(pat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int         c;
    logic [6:0] r;
    logic       t;
  } exp_t;

  exp_t       done_q[$];
  logic [3:0] train_q[$];
  logic [3:0] mbuf[$];
  logic [6:0] seq[$];
  logic [6:0] exp_res;
  logic       exp_to;
  int         tests = 0;
  int         fails = 0;
  exp_t       mon_e;
  logic [3:0] mon_p;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (net_learning_enable) begin
        if (train_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL learn_extra: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_p = train_q.pop_front();
          check("train_pat", 32'(net_pattern), 32'(mon_p));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_extra: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_e = done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(mon_e.c));
          check("result", 32'(result), 32'(mon_e.r));
          check("timeout", 32'(timeout), 32'(mon_e.t));
          check("train_len", 32'(train_q.size()), 32'(0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while ((done_q.size() != 0 || train_q.size() != 0) && k < limit) begin
      tick();
      k++;
    end
    tests++;
    if (k >= limit) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0",
               done_q.size() + train_q.size());
      done_q.delete();
      train_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    train_q.delete();
    done_q.delete();
    mbuf.delete();
    exp_res = '0;
    exp_to = 1'b0;
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] d);
    logic acc;
    acc = (mbuf.size() < NUM_PAT);
    load_valid = 1'b1;
    load_data = d;
    #1;
    check("load_ready", 32'(load_ready), 32'(acc));
    if (acc) mbuf.push_back(d);
    tick();
    load_valid = 1'b0;
    check("pat_count", 32'(pat_count), 32'(mbuf.size()));
  endtask

  task automatic do_clear();
    clear_patterns = 1'b1;
    tick();
    clear_patterns = 1'b0;
    mbuf.delete();
    check("clear_cnt", 32'(pat_count), 32'(0));
  endtask

  task automatic push_train();
    int n;
    n = mbuf.size();
    for (int e = 0; e < EPOCHS; e++)
      for (int p = 0; p < n; p++)
        for (int h = 0; h < HOLD; h++)
          train_q.push_back(mbuf[p]);
    done_q.push_back('{cyc + 1 + EPOCHS * n * HOLD, exp_res, exp_to});
  endtask

  task automatic do_train();
    train_start = 1'b1;
    push_train();
    tick();
    train_start = 1'b0;
    check("train_busy", 32'(busy), 32'(1));
    drain(400);
  endtask

  task automatic do_recall(input logic [3:0] pr);
    int   run;
    int   endj;
    logic to;
    run = 0;
    endj = -1;
    to = 1'b0;
    for (int j = 1; j < seq.size(); j++) begin
      run = (seq[j] == seq[j-1]) ? run + 1 : 0;
      if (run == STABLE) begin
        endj = j;
        break;
      end
`ifdef HOPFIELD_SEQ_TIMEOUT_EN
      if (j == TMO) begin
        endj = j;
        to = 1'b1;
        break;
      end
`endif
    end
    if (endj < 0) begin
      $display("FAIL recall_seq: got no end expected an end");
      $fatal(1);
    end
    probe = pr;
    net_spikes = seq[0];
    recall_start = 1'b1;
    done_q.push_back('{cyc + endj + 1, seq[endj], to});
    exp_res = seq[endj];
    exp_to = to;
    tick();
    recall_start = 1'b0;
    check("recall_pat", 32'(net_pattern), 32'(pr));
    check("recall_learn", 32'(net_learning_enable), 32'(0));
    check("recall_busy", 32'(busy), 32'(1));
    for (int j = 1; j <= endj; j++) begin
      net_spikes = seq[j];
      tick();
    end
    drain(20);
    check("pat_hold", 32'(net_pattern), 32'(pr));
    check("to_hold", 32'(timeout), 32'(exp_to));
    check("res_hold", 32'(result), 32'(exp_res));
  endtask

  task automatic rand_seq();
    logic [6:0] a;
    logic [6:0] b;
    int         len;
    seq.delete();
    a = 7'($urandom);
    b = a ^ 7'h41;
    len = $urandom_range(4, 30);
    for (int i = 0; i < len; i++)
      seq.push_back($urandom_range(0, 2) == 0 ? b : a);
    a = 7'($urandom);
    for (int i = 0; i <= STABLE; i++) seq.push_back(a);
  endtask

  initial begin
    reset = 1'b1;
    load_valid = 1'b0;
    load_data = '0;
    clear_patterns = 1'b0;
    train_start = 1'b0;
    recall_start = 1'b0;
    probe = '0;
    net_spikes = '0;
    exp_res = '0;
    exp_to = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_timeout", 32'(timeout), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_count", 32'(pat_count), 32'(0));
    check("rst_pattern", 32'(net_pattern), 32'(0));
    check("rst_learn", 32'(net_learning_enable), 32'(0));
    check("rst_ready", 32'(load_ready), 32'(1));

    // Train with an empty buffer is ignored.
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
    check("empty_train", 32'(busy), 32'(0));
    repeat (3) tick();

    // Fill the buffer, then one dropped load.
    do_load(4'hA);
    do_load(4'h5);
    do_load(4'($urandom));
    do_load(4'($urandom));
    do_load(4'hF);
    do_train();

    // Constant spikes converge three compares after start.
    seq.delete();
    for (int i = 0; i < 8; i++) seq.push_back(7'h55);
    do_recall(4'h3);

    for (int it = 0; it < 3; it++) begin
      do_clear();
      for (int i = 0; i < int'($urandom_range(1, NUM_PAT)); i++)
        do_load(4'($urandom));
      do_train();
      for (int r = 0; r < 3; r++) begin
        rand_seq();
        do_recall(4'($urandom));
      end
    end

    // Toggling spikes: timeout when enabled, otherwise wait.
    seq.delete();
    for (int i = 0; i < 200; i++) seq.push_back(i[0] ? 7'h2A : 7'h55);
    for (int i = 0; i <= STABLE; i++) seq.push_back(7'h11);
    do_recall(4'h9);

    // Simultaneous train/recall/load with one stored pattern.
    do_clear();
    do_load(4'h6);
    train_start = 1'b1;
    recall_start = 1'b1;
    load_valid = 1'b1;
    load_data = 4'hC;
    #1;
    check("busy_ready", 32'(load_ready), 32'(0));
    push_train();
    tick();
    train_start = 1'b0;
    recall_start = 1'b0;
    load_valid = 1'b0;
    check("multi_cnt", 32'(pat_count), 32'(1));
    check("multi_busy", 32'(busy), 32'(1));
    drain(100);

    // Reset in the middle of a training run.
    do_clear();
    do_load(4'hA);
    do_load(4'h5);
    train_start = 1'b1;
    push_train();
    tick();
    train_start = 1'b0;
    repeat (20) tick();
    do_reset();
    check("mid_busy", 32'(busy), 32'(0));
    check("mid_learn", 32'(net_learning_enable), 32'(0));
    check("mid_count", 32'(pat_count), 32'(0));
    check("mid_done", 32'(done), 32'(0));
    check("mid_result", 32'(result), 32'(0));
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hopfield_sequencer.md
HOPFIELD_SEQUENCER -- requirements
Module: hopfield_sequencer

Interface
- REQ-001: Parameter NUM_PAT, 4, pattern buffer depth (patterns of 4 bits).
- REQ-002: Parameter HOLD_CYCLES, 8, cycles each pattern is presented per training pass.
- REQ-003: Parameter EPOCHS, 4, full passes over the buffer per training run.
- REQ-004: Parameter STABLE_CYCLES, 3, consecutive equal spike compares that declare convergence.
- REQ-005: Parameter TIMEOUT, 32, maximum RECALL cycles (used only with the timeout feature).
- REQ-006: Ports SHALL be:
  - clk  in  1  single clock; all logic on its rising edge.
  - reset  in  1  synchronous, active-high reset.
  - load_valid  in  1  pattern-load request.
  - load_data  in  4  pattern to store.
  - load_ready  out  1  buffer accepts load_data this cycle.
  - clear_patterns  in  1  empty the buffer (IDLE only).
  - train_start  in  1  start a training run.
  - recall_start  in  1  start a recall run.
  - probe  in  4  recall cue.
  - net_spikes  in  7  spike vector from the network.
  - net_learning_enable  out  1  drives the network learning enable.
  - net_pattern  out  4  drives the network pattern input.
  - busy  out  1  high in TRAIN or RECALL.
  - done  out  1  one-cycle completion pulse.
  - timeout  out  1  last recall ended without convergence.
  - result  out  7  spike vector captured at end of recall.
  - pat_count  out  3  number of stored patterns.

Function
- REQ-007: The FSM SHALL have four states: IDLE, TRAIN, RECALL, DONE. DONE lasts exactly one cycle with done=1, then the FSM returns to IDLE.
- REQ-008: load_ready SHALL equal (state==IDLE && pat_count<NUM_PAT && !train_start && !recall_start && !clear_patterns).
- REQ-009: On load_valid && load_ready, load_data SHALL be written to buffer slot pat_count, and pat_count SHALL increment. A load_valid while the buffer is full SHALL be dropped, with no overwrite.
- REQ-010: In IDLE, priority SHALL be clear_patterns > train_start > recall_start > load. clear_patterns sets pat_count to 0.
- REQ-011: train_start with pat_count==0 SHALL be ignored: the FSM stays in IDLE and no done pulse is produced.
- REQ-012: Accepted train_start SHALL move the FSM to TRAIN with index=0, hold=0, epoch=0.
- REQ-013: In TRAIN:
  - net_learning_enable=1 and net_pattern=buf[index].
  - hold increments every cycle; at HOLD_CYCLES-1 it wraps to 0 and index increments.
  - index wraps at pat_count-1 and epoch increments.
  - after the last cycle of epoch EPOCHS-1, the FSM moves to DONE.
  - TRAIN lasts exactly EPOCHS*pat_count*HOLD_CYCLES cycles.
- REQ-014: Accepted recall_start SHALL latch probe into net_pattern, sample net_spikes into prev, clear the stable and cycle counters, clear timeout, and enter RECALL.
- REQ-015: In RECALL:
  - net_learning_enable=0.
  - Each cycle compares net_spikes with prev: stable increments when equal and resets to 0 when different; prev is then updated.
- REQ-016: When the stable count reaches STABLE_CYCLES, result SHALL capture net_spikes and the FSM SHALL enter DONE.
- REQ-017: train_start, recall_start, load_valid and clear_patterns SHALL be ignored outside IDLE.
- REQ-018: net_pattern SHALL hold its last value in IDLE and DONE. net_learning_enable SHALL be 0 outside TRAIN.
- REQ-019: busy SHALL be registered-state decoded, with no combinational path from any input to busy or done.

Reset
- REQ-020: When reset is high at a rising clk edge, the following SHALL take effect regardless of state, aborting any run:
  - state=IDLE and pat_count=0.
  - net_pattern=0, net_learning_enable=0, busy=0, done=0, timeout=0, result=0.
  - all counters cleared; buffer contents don't-care.

Configuration
- REQ-021: With HOPFIELD_SEQ_TIMEOUT_EN defined:
  - a RECALL cycle counter runs.
  - when it reaches TIMEOUT-1 without convergence, result SHALL capture net_spikes, timeout SHALL be set, and the FSM SHALL enter DONE.
  - if convergence and timeout coincide, convergence wins and timeout=0.
  - timeout holds until the next accepted recall_start or reset.
- REQ-022: Without HOPFIELD_SEQ_TIMEOUT_EN, RECALL SHALL wait indefinitely for convergence, timeout SHALL be tied 0, and no cycle counter SHALL exist.

Verification
- REQ-023: Load 4'hA, 4'h5, then a third load_valid with NUM_PAT=2 override -> pat_count=2, load_ready=0, third load dropped.
- REQ-024: Defaults with 2 patterns loaded, train_start pulse -> net_learning_enable high for exactly 64 cycles, net_pattern A(8 cycles),5(8 cycles) repeated 4 times, done pulses on the next cycle.
- REQ-025: recall_start at cycle 0, probe=4'h3, net_spikes constant 7'h55 -> net_pattern=3, done=1 in cycle 4, result=7'h55, timeout=0.
- REQ-026: HOPFIELD_SEQ_TIMEOUT_EN defined, net_spikes toggling every cycle -> done and timeout=1 after 32 RECALL cycles, result=last net_spikes. Without the macro -> no done after 1000 cycles.
- REQ-027: reset asserted in cycle 20 of TRAIN -> next cycle state IDLE, net_learning_enable=0, pat_count=0, busy=0, no done pulse.
- REQ-028: train_start and recall_start asserted together with pat_count=1 -> TRAIN entered. The same cycle's load_valid is not accepted.
